// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes,
// FSM state encodings and the latched request payload.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  // Byte-lane write strobes for a store; halfwords/words ignore low address bits.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised data array: byte-strobed synchronous write, combinational read.
module dmem_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata_c
);

  logic [31:0] r_mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder in front of a DEPTH x 32 data array.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned halfword/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_req_ready;
  logic          w_done;
  req_t          r_req;

  logic          w_oob, w_f3_ok, w_misalign, w_err;
  logic [1:0]    w_lane;
  logic [3:0]    w_be, w_sram_be;
  logic [31:0]   w_wdata, w_rd_word, w_ld, w_resp_data;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // State, latency counter and ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CW'(LAT - 1);
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = r_req_ready;

  // Request is captured only on acceptance; inputs are ignored otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
    end else if (r_state == ST_IDLE && req_valid) begin
      r_req <= '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
    end
  end

  assign w_lane  = r_req.addr[1:0];
  assign w_oob   = {2'b00, r_req.addr[31:2]} >= 32'(DEPTH);
  assign w_f3_ok = r_req.we ? (r_req.funct3 inside {F3_B, F3_H, F3_W})
                            : (r_req.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = ((r_req.funct3[1:0] == 2'b01) && w_lane[0]) ||
                      ((r_req.funct3[1:0] == 2'b10) && (w_lane != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err = w_oob || !w_f3_ok || w_misalign;

  assign w_be      = store_be(r_req.funct3, w_lane);
  assign w_sram_be = (w_done && r_req.we && !w_err) ? w_be : 4'b0000;

  always_comb begin
    w_wdata = r_req.wdata;
    case (r_req.funct3)
      F3_B:    w_wdata = {4{r_req.wdata[7:0]}};
      F3_H:    w_wdata = {2{r_req.wdata[15:0]}};
      default: w_wdata = r_req.wdata;
    endcase
  end

  dmem_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk       (clk),
    .i_be      (w_sram_be),
    .i_addr    (r_req.addr[AW+1:2]),
    .i_wdata   (w_wdata),
    .o_rdata_c (w_rd_word)
  );

  // Load lane extraction and extension
  always_comb begin
    w_byte = w_rd_word[7:0];
    case (w_lane)
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      2'd3:    w_byte = w_rd_word[31:24];
      default: w_byte = w_rd_word[7:0];
    endcase
    w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_ld   = 32'h0;
    case (r_req.funct3)
      F3_B:    w_ld = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_ld = {{16{w_half[15]}}, w_half};
      F3_W:    w_ld = w_rd_word;
      F3_BU:   w_ld = {24'h0, w_byte};
      F3_HU:   w_ld = {16'h0, w_half};
      default: w_ld = 32'h0;
    endcase
  end

  assign w_resp_data = (r_req.we || w_err) ? 32'h0 : w_ld;

  // Response registers held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (w_done) begin
      resp_valid <= 1'b1;
      resp_rdata <= w_resp_data;
      resp_err   <= w_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, LAT=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3);
    check("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
    req_funct3 = 3'b111;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("ready_after_consume", 32'(req_ready), 32'd1);
    check("valid_after_consume", 32'(resp_valid), 32'd0);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic [31:0] exp_data, input logic exp_err);
    issue(we, addr, wdata, f3);
    wait_resp(tag);
    check({tag, "_rdata"}, resp_rdata, exp_data);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; resp_ready = 1'b0;
    #23;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    xact("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD_BEEF, 1'b0);
    xact("lb13", 1'b0, 32'h13, 32'h0, F3_B, 32'hFFFF_FFDE, 1'b0);
    xact("lbu13", 1'b0, 32'h13, 32'h0, F3_BU, 32'h0000_00DE, 1'b0);
    xact("lh12", 1'b0, 32'h12, 32'h0, F3_H, 32'hFFFF_DEAD, 1'b0);
    xact("sb11", 1'b1, 32'h11, 32'h0000_0055, F3_B, 32'h0, 1'b0);
    xact("lw10_sb", 1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD_55EF, 1'b0);
    xact("lhu10", 1'b0, 32'h10, 32'h0, F3_HU, 32'h0000_55EF, 1'b0);
    xact("lb10", 1'b0, 32'h10, 32'h0, F3_B, 32'hFFFF_FFEF, 1'b0);
    xact("sh12", 1'b1, 32'h12, 32'h0000_A5A5, F3_H, 32'h0, 1'b0);
    xact("lw10_sh", 1'b0, 32'h10, 32'h0, F3_W, 32'hA5A5_55EF, 1'b0);

    // Backpressure: response must hold while resp_ready is low
    issue(1'b0, 32'h10, 32'h0, F3_W);
    wait_resp("stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_rdata", resp_rdata, 32'hA5A5_55EF);
      check("stall_err", 32'(resp_err), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    consume();

    // Out-of-range and undefined-funct3 accesses
    xact("sw0", 1'b1, 32'h0, 32'h1111_1111, F3_W, 32'h0, 1'b0);
    xact("sw_oob", 1'b1, 32'h1000, 32'hFFFF_FFFF, F3_W, 32'h0, 1'b1);
    xact("lw0", 1'b0, 32'h0, 32'h0, F3_W, 32'h1111_1111, 1'b0);
    xact("lw_oob", 1'b0, 32'h1000, 32'h0, F3_W, 32'h0, 1'b1);
    xact("ld_f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    xact("ld_f3_110", 1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1);
    xact("st_f3_100", 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1);
    xact("lw10_after_bad", 1'b0, 32'h10, 32'h0, F3_W, 32'hA5A5_55EF, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    xact("lw12_mis", 1'b0, 32'h12, 32'h0, F3_W, 32'h0, 1'b1);
    xact("lh13_mis", 1'b0, 32'h13, 32'h0, F3_H, 32'h0, 1'b1);
    xact("sw11_mis", 1'b1, 32'h11, 32'h0, F3_W, 32'h0, 1'b1);
    xact("lw10_after_mis", 1'b0, 32'h10, 32'h0, F3_W, 32'hA5A5_55EF, 1'b0);
`else
    xact("lw12_force", 1'b0, 32'h12, 32'h0, F3_W, 32'hA5A5_55EF, 1'b0);
    xact("lh13_force", 1'b0, 32'h13, 32'h0, F3_H, 32'hFFFF_A5A5, 1'b0);
`endif

    // Reset while a store is in BUSY must drop it
    xact("sw20_prior", 1'b1, 32'h20, 32'h0000_5678, F3_W, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'h0000_1234, F3_W);
    check("busy_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_busy_valid", 32'(resp_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 32'(req_ready), 32'd1);
    check("rst_release_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check("rst_idle_valid", 32'(resp_valid), 32'd0);
    xact("lw20", 1'b0, 32'h20, 32'h0, F3_W, 32'h0000_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
